// File: rtl/watch_set_ctrl.sv
// rtl/watch_set_ctrl.sv - run/set controller for the hour-minute-second watch counter
//
// Purpose: generates the one-cycle second tick for the counter's enable from a
// programmable prescaler, and runs the button-driven hour/minute setting FSM
// that ends with a one-cycle load strobe into the counter.
//
// Ports:
//   clk, rst            single clock, asynchronous active-high reset
//   i_freq              clock cycles per second tick (0 or 1 = every cycle)
//   i_run               run-enable level
//   i_mode_pulse        advances IDLE/RUN -> SET_HOUR -> SET_MIN -> RUN/IDLE
//   i_inc_pulse         increments the field being edited
//   i_cur_min/hour      live counter value, captured when setting starts
//   o_tick              second tick to the counter's en
//   o_load              one-cycle load strobe
//   o_load_sec/min/hour load value (seconds always 0)
//   o_state             0 IDLE, 1 RUN, 2 SET_HOUR, 3 SET_MIN
module watch_set_ctrl #(
  parameter int P_COUNT_BIT = 30,
  parameter int P_SEC_BIT   = 6,
  parameter int P_MIN_BIT   = 6,
  parameter int P_HOUR_BIT  = 5
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [P_COUNT_BIT-1:0] i_freq,
  input  logic                   i_run,
  input  logic                   i_mode_pulse,
  input  logic                   i_inc_pulse,
  input  logic [P_MIN_BIT-1:0]   i_cur_min,
  input  logic [P_HOUR_BIT-1:0]  i_cur_hour,
  output logic                   o_tick,
  output logic                   o_load,
  output logic [P_SEC_BIT-1:0]   o_load_sec,
  output logic [P_MIN_BIT-1:0]   o_load_min,
  output logic [P_HOUR_BIT-1:0]  o_load_hour,
  output logic [1:0]             o_state
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_RUN      = 2'd1,
    S_SET_HOUR = 2'd2,
    S_SET_MIN  = 2'd3
  } state_t;

  localparam logic [P_COUNT_BIT-1:0] CNT_ONE  = P_COUNT_BIT'(1);
  localparam logic [P_HOUR_BIT-1:0]  HOUR_MAX = P_HOUR_BIT'(23);
  localparam logic [P_MIN_BIT-1:0]   MIN_MAX  = P_MIN_BIT'(59);

  state_t                 state_q, state_d;
  logic [P_COUNT_BIT-1:0] cnt_q, cnt_d;
  logic [P_HOUR_BIT-1:0]  edit_hour_q, edit_hour_d;
  logic [P_MIN_BIT-1:0]   edit_min_q, edit_min_d;
  logic                   load_q, load_d;
  logic                   cnt_wrap;

  // i_freq of 0 or 1 would underflow i_freq-1, so treat both as "every cycle".
  // The >= keeps the prescaler from running away if i_freq drops mid-run.
  assign cnt_wrap = (i_freq <= CNT_ONE) || (cnt_q >= (i_freq - CNT_ONE));

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      edit_hour_q <= '0;
      edit_min_q  <= '0;
      load_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      edit_hour_q <= edit_hour_d;
      edit_min_q  <= edit_min_d;
      load_q      <= load_d;
    end
  end

  // Next-state logic; mode pulse always wins over run level and increments
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (i_mode_pulse)  state_d = S_SET_HOUR;
        else if (i_run)    state_d = S_RUN;
      end
      S_RUN: begin
        if (i_mode_pulse)  state_d = S_SET_HOUR;
        else if (!i_run)   state_d = S_IDLE;
      end
      S_SET_HOUR: begin
        if (i_mode_pulse)  state_d = S_SET_MIN;
      end
      S_SET_MIN: begin
        if (i_mode_pulse)  state_d = i_run ? S_RUN : S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Prescaler, edit registers and load strobe
  always_comb begin
    cnt_d       = '0;
    edit_hour_d = edit_hour_q;
    edit_min_d  = edit_min_q;
    load_d      = 1'b0;

    // Counting only continues while staying in RUN; every other path parks it at 0
    // so each RUN entry starts a full tick period.
    if (state_q == S_RUN && state_d == S_RUN) begin
      cnt_d = cnt_wrap ? '0 : (cnt_q + CNT_ONE);
    end

    if ((state_q == S_IDLE || state_q == S_RUN) && i_mode_pulse) begin
      edit_hour_d = (i_cur_hour > HOUR_MAX) ? '0 : i_cur_hour;
      edit_min_d  = (i_cur_min > MIN_MAX) ? '0 : i_cur_min;
    end

    if (state_q == S_SET_HOUR && !i_mode_pulse && i_inc_pulse) begin
      edit_hour_d = (edit_hour_q == HOUR_MAX) ? '0 : (edit_hour_q + P_HOUR_BIT'(1));
    end

    if (state_q == S_SET_MIN && !i_mode_pulse && i_inc_pulse) begin
      edit_min_d = (edit_min_q == MIN_MAX) ? '0 : (edit_min_q + P_MIN_BIT'(1));
    end

    load_d = (state_q == S_SET_MIN) && i_mode_pulse;
  end

  // Outputs decoded from registers. The load cycle suppresses the tick so the
  // counter never sees load and enable together (only matters for i_freq <= 1).
  assign o_tick      = (state_q == S_RUN) && cnt_wrap && !load_q;
  assign o_load      = load_q;
  assign o_load_sec  = '0;
  assign o_load_min  = edit_min_q;
  assign o_load_hour = edit_hour_q;
  assign o_state     = state_q;

endmodule

// File: doc/watch_set_ctrl.md
# watch_set_ctrl

Run/set controller for the hour-minute-second watch counter. It has two jobs:
- Generate the one-cycle second tick that drives the counter's `en` input, using a programmable prescaler.
- Run a button-driven time-setting state machine that edits hour and minute, then loads the new time into the counter with a one-cycle load strobe.

It sits between the user inputs (run switch, mode and increment buttons, already debounced to pulses) and the watch counter datapath.

## Interface
Parameters:
- `P_COUNT_BIT`, 30: prescaler and `i_freq` width.
- `P_SEC_BIT`, 6: seconds field width.
- `P_MIN_BIT`, 6: minutes field width.
- `P_HOUR_BIT`, 5: hours field width.

Ports:
- `clk`  in  1  single clock.
- `rst`  in  1  asynchronous, active-high reset.
- `i_freq`  in  `P_COUNT_BIT`  clock cycles per second tick.
- `i_run`  in  1  run-enable level.
- `i_mode_pulse`  in  1  one-cycle pulse; advances the set sequence.
- `i_inc_pulse`  in  1  one-cycle pulse; increments the selected field.
- `i_cur_min`  in  `P_MIN_BIT`  live minute value from the counter.
- `i_cur_hour`  in  `P_HOUR_BIT`  live hour value from the counter.
- `o_tick`  out  1  second tick, connects to the counter's `en`.
- `o_load`  out  1  one-cycle load strobe to the counter.
- `o_load_sec`  out  `P_SEC_BIT`  load value; always 0.
- `o_load_min`  out  `P_MIN_BIT`  load value; equals the minute edit register.
- `o_load_hour`  out  `P_HOUR_BIT`  load value; equals the hour edit register.
- `o_state`  out  2  0 = IDLE, 1 = RUN, 2 = SET_HOUR, 3 = SET_MIN.

## Operation
State registers:
- FSM state.
- Prescaler `cnt` (`P_COUNT_BIT` bits).
- `edit_hour`, `edit_min`.
- `o_load` flag.

Reset values:
- state = IDLE, `cnt` = 0, edits = 0.
- `o_tick` = 0, `o_load` = 0.
- `o_load_*` = 0, `o_state` = 0.

State transitions (`i_mode_pulse` has priority over `i_inc_pulse`; an increment in the same cycle as a mode pulse is dropped):
- **IDLE**
  - `cnt` is held at 0.
  - `i_mode_pulse` → SET_HOUR, capturing the edits (see Capture rule).
  - Otherwise `i_run` = 1 → RUN.
- **RUN**
  - `cnt` increments every cycle.
  - When `cnt` ≥ `i_freq`−1, `cnt` wraps to 0. The `≥` makes a mid-run `i_freq` decrease safe.
  - `i_mode_pulse` → SET_HOUR, capturing the edits, with `cnt` cleared to 0.
  - Otherwise `i_run` = 0 → IDLE, with `cnt` cleared to 0.
- **SET_HOUR**
  - `i_inc_pulse`: `edit_hour` = (`edit_hour` == 23) ? 0 : `edit_hour`+1.
  - `i_mode_pulse` → SET_MIN.
  - `i_run` is ignored.
- **SET_MIN**
  - `i_inc_pulse`: `edit_min` = (`edit_min` == 59) ? 0 : `edit_min`+1.
  - `i_mode_pulse` → RUN if `i_run` = 1, else IDLE. On this transition `o_load` is set for exactly one cycle.

Capture rule:
- `edit_hour` takes `i_cur_hour`, or 0 if the value is greater than 23.
- `edit_min` takes `i_cur_min`, or 0 if the value is greater than 59.

Tick rule:
- `o_tick` = (state == RUN) and (`cnt` ≥ `i_freq`−1), decoded from registers only; there is no input-to-output path.
- `i_freq` = 0 or 1: tick every cycle in RUN.

Output rules:
- `o_tick` is never high outside RUN.
- `o_load` is never high in the same cycle as `o_tick`.
- `o_load_min` and `o_load_hour` continuously reflect the edit registers.
- `o_state` is the registered state.

## Timing
- First RUN cycle has `cnt` = 0, so the first `o_tick` occurs in the `i_freq`-th RUN cycle. The tick period is `i_freq` cycles.
- `o_load` is high in the first cycle after the edge that leaves SET_MIN. The new state (RUN or IDLE) is visible in that same cycle.
  - If the new state is RUN, the first tick follows `i_freq` cycles after that RUN entry.
- Edit capture is visible in the first SET_HOUR cycle.
- An increment is visible on `o_load_*` one cycle after the pulse.
- Reset asserted mid-set aborts immediately to IDLE with edits at 0 and no load strobe. Mid-RUN reset also clears `cnt`.

## Test plan
- **Basic tick:** reset, then `i_freq` = 10, `i_run` = 1 → `o_state` = 1, and `o_tick` is a single-cycle pulse every 10 cycles, the first on the 10th RUN cycle.
- **Run stop / resume:** run 25 cycles, drop `i_run` for 3 cycles, then restore it → no tick while in IDLE, and the next tick comes exactly 10 cycles after re-entering RUN.
- **Set with wraps:**
  - Setup: `i_cur_hour` = 22, `i_cur_min` = 58, RUN.
  - Stimulus: mode; inc ×3; mode; inc ×2; mode.
  - Required: `edit_hour` goes 22 → 23 → 0 → 1, `edit_min` goes 58 → 59 → 0.
  - Required: `o_load` pulses once with (sec, min, hour) = (0, 0, 1), then state = RUN.
- **Priority and ignore:** mode and inc asserted together in SET_HOUR → state becomes SET_MIN with `edit_hour` unchanged. `i_run` = 0 while in SET_HOUR → state remains SET_HOUR.
- **Clamp / exit:**
  - Invalid capture: `i_cur_hour` = 30, `i_cur_min` = 63 when entering set → edits = 0.
  - Leave SET_MIN with `i_run` = 0 → `o_load` pulses and state = IDLE.
- **Async reset mid-set:** assert `rst` between edges while in SET_MIN → all outputs are 0 immediately, no `o_load` pulse, and `o_state` = 0.
